// File: rtl/tqvp_reg_arbiter_pkg.sv
// tqvp_arb_pkg: shared types and constants for the TinyQV register-port arbiter.
//   arb_state_t   : arbiter FSM states
//   REQ_SPI/SEQ   : requester ids as seen on grant_id
//   LOCK_CNT_W    : width of the consecutive-lock counter
package tqvp_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_t;

   localparam logic REQ_SPI = 1'b0;
   localparam logic REQ_SEQ = 1'b1;

   localparam int LOCK_CNT_W = 4;

endpackage

// File: rtl/tqvp_reg_arbiter_if.sv
// tqvp_reg_arbiter_if: one requester's single-beat command/ack channel.
//   req/we/lock/addr/wdata : command, driven by the requester
//   ack/rdata              : completion pulse and read data, driven by the arbiter
//   master : requester side, slave : arbiter side
interface tqvp_reg_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);

   logic              req;
   logic              we;
   logic              lock;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, lock, addr, wdata, input ack, rdata);
   modport slave  (input req, we, lock, addr, wdata, output ack, rdata);

endinterface

// File: rtl/tqvp_reg_arbiter_rr_pick2.sv
// tqvp_rr_pick2: combinational two-way round-robin picker.
//   req_i   : request vector {r1, r0}
//   last_i  : requester granted last
//   force_i : lock budget exhausted, tie must go away from last_i
//   hold_i  : last grant was locked, tie stays with last_i
//   win_o   : chosen requester, valid_o : any request present
module tqvp_rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       force_i,
   input  logic       hold_i,
   output logic       win_o,
   output logic       valid_o
);

   assign valid_o = |req_i;

   // A single requester always wins; a tie goes to last_i only under an unexpired lock.
   assign win_o = (req_i == 2'b11) ? ((hold_i && !force_i) ? last_i : ~last_i) : req_i[1];

endmodule

// File: rtl/tqvp_reg_arbiter.sv
// tqvp_reg_arbiter: shares the peripheral register port between the SPI bridge (r0)
// and the sequencer (r1) with round-robin grant and a bounded lock.
//   clk, rst            : clock, asynchronous active-high reset
//   r0, r1              : requester channels (slave side)
//   address/data_in     : command to the peripheral, held outside ACCESS
//   data_write          : one-cycle write strobe, only in ACCESS
//   data_out            : peripheral read data, combinational on address
//   busy                : high in ACCESS or ACK
//   grant_id            : requester currently or last granted
module tqvp_reg_arbiter
   import tqvp_arb_pkg::*;
#(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int LOCK_MAX = 4
) (
   input  logic               clk,
   input  logic               rst,
   tqvp_reg_arbiter_if.slave  r0,
   tqvp_reg_arbiter_if.slave  r1,
   output logic [ADDR_W-1:0]  address,
   output logic [DATA_W-1:0]  data_in,
   output logic               data_write,
   input  logic [DATA_W-1:0]  data_out,
   output logic               busy,
   output logic               grant_id
);

   arb_state_t            state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  hold_q, hold_d;
   logic                  force_q, force_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  write_q, write_d;
   logic [DATA_W-1:0]     rdata0_q, rdata0_d;
   logic [DATA_W-1:0]     rdata1_q, rdata1_d;

   logic                  win, valid, sel_we, sel_lock;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_W-1:0]     sel_wdata;
   logic [LOCK_CNT_W-1:0] run;

   tqvp_rr_pick2 u_pick (
      .req_i   ({r1.req, r0.req}),
      .last_i  (grant_q),
      .force_i (force_q),
      .hold_i  (hold_q),
      .win_o   (win),
      .valid_o (valid)
   );

   assign sel_we    = win ? r1.we    : r0.we;
   assign sel_lock  = win ? r1.lock  : r0.lock;
   assign sel_addr  = win ? r1.addr  : r0.addr;
   assign sel_wdata = win ? r1.wdata : r0.wdata;

   // Length of the locked run this grant would extend; a grant to the other side starts a new run.
   assign run = (win == grant_q) ? lock_cnt_q + LOCK_CNT_W'(1) : LOCK_CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      hold_d     = hold_q;
      force_d    = force_q;
      lock_cnt_d = lock_cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_d    = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      case (state_q)
         IDLE: if (valid) begin
            state_d    = ACCESS;
            grant_d    = win;
            addr_d     = sel_addr;
            wdata_d    = sel_wdata;
            write_d    = sel_we;
            force_d    = sel_lock && (run == LOCK_CNT_W'(LOCK_MAX));
            hold_d     = sel_lock && !force_d;
            lock_cnt_d = hold_d ? run : '0;
         end
         ACCESS: begin
            state_d = ACK;
            if (!write_q) begin
               if (grant_q) rdata1_d = data_out;
               else rdata0_d = data_out;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // hold_q resets high with grant_q = r0 so the first tie after reset goes to r0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= REQ_SPI;
         hold_q     <= 1'b1;
         force_q    <= 1'b0;
         lock_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         hold_q     <= hold_d;
         force_q    <= force_d;
         lock_cnt_q <= lock_cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         write_q    <= write_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   assign address    = addr_q;
   assign data_in    = wdata_q;
   assign data_write = write_q;
   assign busy       = state_q != IDLE;
   assign grant_id   = grant_q;
   assign r0.ack     = (state_q == ACK) && (grant_q == REQ_SPI);
   assign r1.ack     = (state_q == ACK) && (grant_q == REQ_SEQ);
   assign r0.rdata   = rdata0_q;
   assign r1.rdata   = rdata1_q;

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// tb_tqvp_reg_arbiter: directed and randomized checks of tqvp_reg_arbiter against a
// grant-history reference model.
module tb_tqvp_reg_arbiter;

   localparam int LOCK_MAX = 4;

   typedef struct {
      bit id;
      bit lock;
   } grant_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] address;
   logic [7:0] data_in;
   logic       data_write;
   logic [7:0] data_out;
   logic       busy;
   logic       grant_id;

   int         total = 0;
   int         bad = 0;
   grant_t     hist[$];
   logic [7:0] rd_m[2];

   tqvp_reg_arbiter_if r0 ();
   tqvp_reg_arbiter_if r1 ();

   tqvp_reg_arbiter #(.ADDR_W(4), .DATA_W(8), .LOCK_MAX(LOCK_MAX)) dut (
      .clk        (clk),
      .rst        (rst),
      .r0         (r0),
      .r1         (r1),
      .address    (address),
      .data_in    (data_in),
      .data_write (data_write),
      .data_out   (data_out),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   assign data_out = 8'h10 + {4'h0, address};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Tie priority from grant history: a trailing run of k locked grants by one requester
   // keeps priority unless k is a multiple of LOCK_MAX; anything else rotates.
   function automatic bit tie_winner();
      int k = 0;
      grant_t last;
      if (hist.size() == 0) return 1'b0;
      last = hist[hist.size()-1];
      if (!last.lock) return ~last.id;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i].id != last.id || !hist[i].lock) break;
         k++;
      end
      return (k % LOCK_MAX != 0) ? last.id : ~last.id;
   endfunction

   function automatic int trailing_run();
      int k = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i].id != hist[hist.size()-1].id || !hist[i].lock) break;
         k++;
      end
      return k % LOCK_MAX;
   endfunction

   task automatic drop_reqs();
      r0.req = 1'b0;
      r1.req = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "/busy"}, busy, 0);
      chk({tag, "/acks"}, {r1.ack, r0.ack}, 0);
      chk({tag, "/wr"}, data_write, 0);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      drop_reqs();
      #1;
      check_idle_outputs(tag);
      chk({tag, "/bus"}, {address, data_in, grant_id, r0.rdata, r1.rdata}, 0);
      hist.delete();
      rd_m[0] = 8'h00;
      rd_m[1] = 8'h00;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic round(input string tag, input bit q0, input bit q1, input bit l0, input bit l1,
                        input bit w0, input bit w1, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1, input bit early);
      bit         w;
      bit         we;
      logic [3:0] a;
      @(negedge clk);
      r0.req = q0; r0.lock = l0; r0.we = w0; r0.addr = a0; r0.wdata = d0;
      r1.req = q1; r1.lock = l1; r1.we = w1; r1.addr = a1; r1.wdata = d1;
      if (!q0 && !q1) begin
         @(posedge clk);
         #1;
         check_idle_outputs({tag, "/noreq"});
         return;
      end
      w  = (q0 && q1) ? tie_winner() : q1;
      we = w ? w1 : w0;
      a  = w ? a1 : a0;
      @(posedge clk);
      #1;
      chk({tag, "/acc_busy"}, busy, 1);
      chk({tag, "/gid"}, grant_id, w);
      chk({tag, "/addr"}, address, a);
      if (we) chk({tag, "/wdata"}, data_in, w ? d1 : d0);
      chk({tag, "/wr"}, data_write, we);
      chk({tag, "/acc_acks"}, {r1.ack, r0.ack}, 0);
      hist.push_back('{w, w ? l1 : l0});
      if (!we) rd_m[w] = 8'h10 + {4'h0, a};
      if (early) drop_reqs();
      @(posedge clk);
      #1;
      chk({tag, "/ack_wr"}, data_write, 0);
      chk({tag, "/acks"}, {r1.ack, r0.ack}, w ? 2'b10 : 2'b01);
      chk({tag, "/rdata0"}, r0.rdata, rd_m[0]);
      chk({tag, "/rdata1"}, r1.rdata, rd_m[1]);
      drop_reqs();
      @(posedge clk);
      #1;
      check_idle_outputs({tag, "/post"});
      if (early) repeat (2) begin
         @(posedge clk);
         #1;
         chk({tag, "/no_second"}, busy, 0);
      end
   endtask

   initial begin
      drop_reqs();
      r0.we = 0; r0.lock = 0; r0.addr = 0; r0.wdata = 0;
      r1.we = 0; r1.lock = 0; r1.addr = 0; r1.wdata = 0;
      #1;
      check_idle_outputs("por");
      apply_reset("rst0");

      round("wr0", 1, 0, 0, 0, 1, 0, 4'h3, 4'h0, 8'hA5, 8'h00, 0);
      chk("wr0/gid_const", grant_id, 0);

      apply_reset("rst1");
      for (int i = 0; i < 3; i++) begin
         round("tie", 1, 1, 0, 0, 0, 0, 4'h1, 4'h2, 8'h00, 8'h00, 0);
         chk("tie/gid_const", grant_id, i % 2);
      end
      chk("tie/rd0_const", r0.rdata, 8'h11);
      chk("tie/rd1_const", r1.rdata, 8'h12);

      apply_reset("rst2");
      round("lock_a", 0, 1, 0, 1, 0, 0, 4'h0, 4'h7, 8'h00, 8'h00, 0);
      for (int i = 0; i < 4; i++) begin
         round("lock_b", 1, 1, 0, 1, 0, 1, 4'h4, 4'h8, 8'h00, 8'h5A, 0);
         chk("lock_b/gid_const", grant_id, i == 3 ? 0 : 1);
      end
      chk("lock/cnt", dut.lock_cnt_q, trailing_run());
      chk("lock/cnt_const", dut.lock_cnt_q, 0);

      round("drop", 1, 0, 0, 0, 0, 0, 4'h6, 4'h0, 8'h00, 8'h00, 1);

      @(negedge clk);
      r0.req = 1; r0.we = 1; r0.lock = 0; r0.addr = 4'h5; r0.wdata = 8'h3C;
      @(posedge clk);
      #1;
      chk("rstacc/wr_on", data_write, 1);
      rst = 1'b1;
      drop_reqs();
      #1;
      check_idle_outputs("rstacc");
      chk("rstacc/bus", {address, data_in, grant_id, r0.rdata, r1.rdata}, 0);
      @(posedge clk);
      #1;
      chk("rstacc/no_ack", {r1.ack, r0.ack}, 0);
      hist.delete();
      rd_m[0] = 8'h00;
      rd_m[1] = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      round("rstacc_tie", 1, 1, 0, 0, 0, 0, 4'h1, 4'h2, 8'h00, 8'h00, 0);
      chk("rstacc/gid_const", grant_id, 0);

      repeat (80) begin
         round("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 7) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
